debounced_bcd_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with a multiplexed, active-low seven-segment display driver. It takes three raw push-buttons (increment, decrement, clear), synchronises and debounces each one, and converts presses to single-cycle events with optional hold-to-repeat. It drives a common-anode display of DIGITS digits by time-multiplexing. It is the general successor of the single-digit button counter and is a drop-in top for the board's display/button subsystem.

---
 rtl/debounced_bcd_counter.sv | 226 ++++++++++++++++++++++
 tb/tb_debounced_bcd_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debounced_bcd_counter.sv
// debounced_bcd_counter: debounced inc/dec/clr buttons with hold-to-repeat
// drive a DIGITS-wide BCD counter shown on a muxed active-low 7-seg display.
// Ports: clk, rst_n (async, active-low), btn_inc/btn_dec/btn_clr (raw),
//   count_bcd (digit k at [4k+3:4k]), wrap (pulse), seg {g..a}, an (one-hot low).
module debounced_bcd_counter #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int BLANK_LEADING   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  btn_clr,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
  localparam int FW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // bit 0 = inc, 1 = dec, 2 = clr
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2;
  logic [2:0]    acc, acc_q, press;
  logic [DW-1:0] db_cnt [3];
  logic [HW-1:0] hold [2];
  logic [1:0]    rpt, fire;

  assign btn_raw = {btn_clr, btn_dec, btn_inc};
  assign press   = acc & ~acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_q <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      acc_q <= acc;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == acc[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          acc[b]    <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // hold counts cycles since the last press/repeat event; rpt selects the
  // initial delay or the steady repeat interval
  always_comb begin
    fire = '0;
    for (int b = 0; b < 2; b++) begin
      if (REPEAT_DELAY > 0 && acc[b]) begin
        if (rpt[b]) fire[b] = (hold[b] == HW'(REPEAT_RATE));
        else        fire[b] = (hold[b] == HW'(REPEAT_DELAY));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt <= '0;
      for (int b = 0; b < 2; b++) hold[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!acc[b]) begin
          hold[b] <= '0;
          rpt[b]  <= 1'b0;
        end else if (REPEAT_DELAY > 0) begin
          if (fire[b]) begin
            hold[b] <= HW'(1);
            rpt[b]  <= 1'b1;
          end else begin
            hold[b] <= hold[b] + 1'b1;
          end
        end
      end
    end
  end

  logic                inc_ev, dec_ev, clr_ev;
  logic [4*DIGITS-1:0] inc_val, dec_val, cnt_next;
  logic                cy, bw, wrap_next;

  assign inc_ev = press[0] | fire[0];
  assign dec_ev = press[1] | fire[1];
  assign clr_ev = press[2];

  always_comb begin
    inc_val = count_bcd;
    dec_val = count_bcd;
    cy      = 1'b1;
    bw      = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (cy) begin
        if (count_bcd[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (count_bcd[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_bcd[4*k +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_next  = count_bcd;
    wrap_next = 1'b0;
    unique case (1'b1)
      clr_ev: cnt_next = '0;
      (!clr_ev && inc_ev && !dec_ev): begin
        cnt_next  = inc_val;
        wrap_next = cy;
      end
      (!clr_ev && dec_ev && !inc_ev): begin
        cnt_next  = dec_val;
        wrap_next = bw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else begin
      count_bcd <= cnt_next;
      wrap      <= wrap_next;
    end
  end

  logic [FW-1:0]     rc;
  logic [IW-1:0]     idx, idx_next;
  logic [DIGITS-1:0] lit, an_next;
  logic              nz, blank;
  logic [3:0]        cur;
  logic [6:0]        seg_next;

  always_comb begin
    idx_next = idx;
    if (rc == FW'(REFRESH_CYCLES - 1)) begin
      idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // a digit is lit if it or any more significant digit is non-zero
  always_comb begin
    lit = '0;
    nz  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz     = nz | (count_bcd[4*k +: 4] != 4'd0);
      lit[k] = nz || (k == 0) || (BLANK_LEADING == 0);
    end
  end

  always_comb begin
    cur     = 4'd0;
    blank   = 1'b0;
    an_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        cur        = count_bcd[4*k +: 4];
        blank      = !lit[k];
        an_next[k] = 1'b0;
      end
    end
  end

  always_comb begin
    case (cur)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
    if (blank) seg_next = 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc  <= '0;
      idx <= '0;
      an  <= ~DIGITS'(1);
      seg <= 7'b1000000;
    end else begin
      rc  <= (rc == FW'(REFRESH_CYCLES - 1)) ? '0 : rc + 1'b1;
      idx <= idx_next;
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_debounced_bcd_counter.sv
// tb_debounced_bcd_counter: scoreboard bench for debounced_bcd_counter
// with a 2-digit build and short debounce/refresh/repeat periods.
module tb_debounced_bcd_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] count_bcd;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  debounced_bcd_counter #(
    .DIGITS(2),
    .DEBOUNCE_CYCLES(4),
    .REFRESH_CYCLES(3),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .btn_clr(btn_clr),
    .count_bcd(count_bcd),
    .wrap(wrap),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] v;
    logic       w;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         mdl = 0;
  logic [7:0] prev = 8'h00;
  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] bcd(input int m);
    logic [3:0] t, o;
    t = 4'(m / 10);
    o = 4'(m % 10);
    return {t, o};
  endfunction

  // count_bcd changes are matched in order against queued expectations,
  // including the edge on which each change must land
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (!rst_n) begin
      prev = count_bcd;
    end else begin
      while (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        chk("missed", e.c, cyc);
      end
      if (count_bcd !== prev || wrap !== 1'b0) begin
        if (q.size() == 0) begin
          chk("spurious", {23'd0, wrap, count_bcd}, {24'd0, prev});
        end else begin
          e = q.pop_front();
          chk("count", count_bcd, e.v);
          chk("wrap", wrap, e.w);
          chk("latency", cyc, e.c);
        end
      end
      prev = count_bcd;
    end
  end

  // m: {clr, dec, inc}; buttons held for hold cycles then released
  task automatic press(input logic [2:0] m, input int hold);
    int   e1, nv;
    logic w;
    @(negedge clk);
    {btn_clr, btn_dec, btn_inc} = m;
    e1 = cyc + 1;
    nv = mdl;
    w  = 1'b0;
    if (m[2]) begin
      nv = 0;
    end else if (m[0] && !m[1]) begin
      nv = (mdl + 1) % 100;
      w  = (mdl == 99);
    end else if (m[1] && !m[0]) begin
      nv = (mdl + 99) % 100;
      w  = (mdl == 0);
    end
    if (nv != mdl || w) q.push_back('{e1 + 6, bcd(nv), w});
    mdl = nv;
    repeat (hold) @(negedge clk);
    {btn_clr, btn_dec, btn_inc} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e1;
    repeat (3) @(negedge clk);
    chk("rst_count", count_bcd, 8'h00);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_an", an, 2'b10);
    chk("rst_seg", seg, 7'b1000000);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("scan_an0", an, 2'b10);
    @(posedge clk);
    #1;
    chk("scan_an1", an, 2'b01);
    chk("blank_seg1", seg, 7'b1111111);
    repeat (3) @(posedge clk);
    #1;
    chk("scan_an2", an, 2'b10);
    chk("scan_seg2", seg, 7'b1000000);

    // clean press held 30 cycles: press, then repeats at +20 and +25
    @(negedge clk);
    btn_inc = 1'b1;
    e1 = cyc + 1;
    q.push_back('{e1 + 6, 8'h01, 1'b0});
    q.push_back('{e1 + 26, 8'h02, 1'b0});
    q.push_back('{e1 + 31, 8'h03, 1'b0});
    mdl = 3;
    repeat (30) @(negedge clk);
    btn_inc = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_value", count_bcd, 8'h03);

    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      repeat (2) @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (15) @(negedge clk);
    chk("bounce_value", count_bcd, 8'h03);

    while (mdl != 99) press(3'b001, 8);
    chk("preload99", count_bcd, 8'h99);
    press(3'b001, 8);
    chk("wrap_up", count_bcd, 8'h00);
    press(3'b010, 8);
    chk("wrap_dn", count_bcd, 8'h99);

    press(3'b011, 8);
    chk("inc_dec_cancel", count_bcd, 8'h99);

    press(3'b100, 8);
    chk("clear", count_bcd, 8'h00);
    while (mdl != 45) press(3'b001, 8);
    chk("preload45", count_bcd, 8'h45);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (an == 2'b10) chk("disp_d0", seg, segtab[5]);
      else             chk("disp_d1", {an, seg}, {2'b01, segtab[4]});
    end

    press(3'b111, 8);
    chk("all_three", count_bcd, 8'h00);
    press(3'b001, 8);
    chk("pre_rst", count_bcd, 8'h01);

    @(negedge clk);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count_bcd, 8'h00);
    chk("mid_rst_an", an, 2'b10);
    mdl = 0;
    @(negedge clk);
    rst_n = 1'b1;
    e1 = cyc + 1;
    q.push_back('{e1 + 6, 8'h01, 1'b0});
    mdl = 1;
    repeat (12) @(negedge clk);
    btn_inc = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst", count_bcd, 8'h01);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
